// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Master issues start with operands; slave reports busy/done and the held result.
// No backpressure: start is only taken when the subtractor is idle.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, b_out, ovf
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, b_out, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - b_in, LSB first, one bit per clock.
// Latency: done pulses WIDTH cycles after the accepting edge; next start accepted WIDTH+2 cycles later.
// Backpressure: none; start is sampled only in IDLE and dropped while busy or done.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] res_sr_q, res_sr_d;
    logic             br_q,     br_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic             a_msb_q,  a_msb_d;
    logic             b_msb_q,  b_msb_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             b_out_q,  b_out_d;
    logic             ovf_q,    ovf_d;

    logic             x, y, d_bit, br_nxt;
    logic [WIDTH-1:0] res_nxt;

    // Single full-subtractor cell fed from the operand shift registers
    assign x       = a_sr_q[0];
    assign y       = b_sr_q[0];
    assign d_bit   = x ^ y ^ br_q;
    assign br_nxt  = (~x & y) | (~(x ^ y) & br_q);
    assign res_nxt = {d_bit, res_sr_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_sr_d = res_sr_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        b_out_d  = b_out_q;
        ovf_d    = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_sr_d   = bus.a;
                    b_sr_d   = bus.b;
                    a_msb_d  = bus.a[WIDTH-1];
                    b_msb_d  = bus.b[WIDTH-1];
                    br_d     = bus.b_in;
                    res_sr_d = '0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
                res_sr_d = res_nxt;
                br_d     = br_nxt;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // Overflow judged from the captured operand signs, not live inputs
                    diff_d  = res_nxt;
                    b_out_d = br_nxt;
                    ovf_d   = (a_msb_q != b_msb_q) && (res_nxt[WIDTH-1] != a_msb_q);
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_sr_q <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            b_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_sr_q <= res_sr_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            b_out_q  <= b_out_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.busy  = (state_q == SHIFT);
    assign bus.done  = (state_q == DONE);
    assign bus.diff  = diff_q;
    assign bus.b_out = b_out_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed checks of the 8-bit subtractor plus an exhaustive 4-bit sweep against a - b - b_in.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(8)) if8 ();
    serial_subtractor_if #(.WIDTH(4)) if4 ();

    serial_subtractor #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_subtractor #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One 8-bit operation; pulse_at >= 0 injects a spurious start at that SHIFT cycle.
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic bin, input logic [7:0] ed, input logic eb,
                        input logic eo, input int pulse_at);
        int  busy_n;
        int  done_at;
        @(negedge clk);
        if8.start = 1'b1; if8.a = a; if8.b = b; if8.b_in = bin;
        @(posedge clk);
        #1;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.b_in = 1'b0;
        busy_n  = 0;
        done_at = -1;
        for (int i = 0; i < 20 && done_at < 0; i++) begin
            @(negedge clk);
            if (i == pulse_at) begin
                if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'h01;
            end else begin
                if8.start = 1'b0; if8.a = '0; if8.b = '0;
            end
            if (if8.busy) busy_n++;
            if (if8.done) done_at = i;
        end
        check({tag, "_done_seen"}, 32'(done_at >= 0), 32'd1);
        check({tag, "_latency"}, 32'(done_at), 32'd8);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, "_diff"}, 32'(if8.diff), 32'(ed));
        check({tag, "_b_out"}, 32'(if8.b_out), 32'(eb));
        check({tag, "_ovf"}, 32'(if8.ovf), 32'(eo));
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(if8.done), 32'd0);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bin);
        int          sd;
        logic [4:0]  full;
        bit          seen;
        full = {1'b0, a} - {1'b0, b} - {4'b0, bin};
        sd   = int'($signed(a)) - int'($signed(b)) - int'(bin);
        @(negedge clk);
        if4.start = 1'b1; if4.a = a; if4.b = b; if4.b_in = bin;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (if4.done) seen = 1'b1;
        end
        if (!seen) check($sformatf("w4_timeout_%h_%h_%b", a, b, bin), 32'd0, 32'd1);
        check($sformatf("w4_diff_bout_%h_%h_%b", a, b, bin), 32'({if4.b_out, if4.diff}), 32'(full));
        check($sformatf("w4_ovf_%h_%h_%b", a, b, bin), 32'(if4.ovf), 32'(sd < -8 || sd > 7));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd;
        int last;
        int stray;
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        if8.start = 1'b0; if8.a = '0; if8.b = '0; if8.b_in = 1'b0;
        if4.start = 1'b0; if4.a = '0; if4.b = '0; if4.b_in = 1'b0;
        #12;
        check("rst_busy", 32'(if8.busy), 32'd0);
        check("rst_done", 32'(if8.done), 32'd0);
        check("rst_diff", 32'(if8.diff), 32'd0);
        check("rst_flags", 32'({if8.b_out, if8.ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run8("t1", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, -1);
        run8("t2", 8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0, -1);
        run8("t3a", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, -1);
        run8("t3b", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, -1);
        run8("t4", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, -1);
        run8("t5_ignore", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0, 1'b0, 3);

        // start held high: back-to-back ops, results held through the next SHIFT
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h33; if8.b = 8'h44; if8.b_in = 1'b0;
        nd   = 0;
        last = -1;
        for (int i = 0; i < 60 && nd < 3; i++) begin
            @(negedge clk);
            if (if8.done) begin
                if (nd > 0) check("held_spacing", 32'(i - last), 32'd10);
                last = i;
                nd++;
                check("held_diff", 32'(if8.diff), 32'hEF);
                check("held_flags", 32'({if8.b_out, if8.ovf}), 32'b10);
            end else if (nd == 1 && if8.busy && i == last + 5) begin
                check("held_stable_in_shift", 32'(if8.diff), 32'hEF);
            end
        end
        if8.start = 1'b0;
        check("held_ops", 32'(nd), 32'd3);
        @(negedge clk);

        // Asynchronous reset in the middle of an operation
        @(negedge clk);
        if8.start = 1'b1; if8.a = 8'h5A; if8.b = 8'h23; if8.b_in = 1'b0;
        @(posedge clk);
        #1;
        if8.start = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_busy_before", 32'(if8.busy), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_busy", 32'(if8.busy), 32'd0);
        check("t6_done", 32'(if8.done), 32'd0);
        check("t6_diff", 32'(if8.diff), 32'd0);
        check("t6_flags", 32'({if8.b_out, if8.ovf}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (if8.done || if8.busy) stray++;
        end
        check("t6_no_done_after_reset", 32'(stray), 32'd0);
        run8("t6_next", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, -1);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++)
                    run4(4'(a), 4'(b), 1'(c));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
